ring_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one resource among N requesters.
- Priority is held in a one-hot ring pointer that rotates like a ring counter. After each grant it advances to the position just past the last owner.
- Sits between N client blocks and a single shared datapath. Drives a one-hot grant vector and an encoded owner index for the datapath mux.

---
 rtl/ring_rr_arbiter.sv | 147 ++++++++++++++
 tb/tb_ring_rr_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter: a one-hot ring pointer sets priority and moves past each owner on release.
// Optional per-owner grant limit is compiled in with `define RING_ARB_HOLD_LIMIT_EN.
module ring_rr_arbiter #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic [N-1:0]   ptr,
  output logic           dbg_state
);

  if (N < 2 || N > 16 || IDW < $clog2(N) || MAX_HOLD < 1) begin : g_bad_cfg
    $error("ring_rr_arbiter: illegal parameter combination");
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   w_gnt_nxt;
  logic [N-1:0]   w_ptr_nxt;
  logic           w_valid_nxt;
  logic [IDW-1:0] w_id_nxt;
  logic [N-1:0]   w_owner_rotl;
  logic [N-1:0]   w_scan_ptr;
  logic [N-1:0]   w_scan_mask;
  logic [N-1:0]   w_hi;
  logic [N-1:0]   w_pick;
  logic [N-1:0]   w_win_oh;
  logic [IDW-1:0] w_win_idx;
  logic           w_win_found;
  logic           w_force;
  logic           w_release;

  assign dbg_state    = (r_state == BUSY);
  assign w_owner_rotl = {gnt[N-2:0], gnt[N-1]};

`ifdef RING_ARB_HOLD_LIMIT_EN
  localparam int HCW = $clog2(MAX_HOLD + 1);
  logic [HCW-1:0] r_hold_cnt;
  logic [HCW-1:0] w_hold_nxt;
  // The counter lags the cycle in progress by one, so MAX_HOLD-1 here means
  // the owner is completing its MAX_HOLD-th grant cycle at this edge.
  assign w_force = (r_hold_cnt >= HCW'(MAX_HOLD - 1)) && (|(req & ~gnt));
`else
  assign w_force = 1'b0;
`endif

  assign w_release = (r_state == BUSY) && (!(|(req & gnt)) || w_force);

  // While busy the scan already assumes a release: it starts just past the
  // owner and excludes the owner, so a release can hand over in one edge.
  assign w_scan_ptr  = (r_state == BUSY) ? w_owner_rotl : ptr;
  assign w_scan_mask = (r_state == BUSY) ? (req & ~gnt) : req;

  // Requests at or above the pointer win first; otherwise wrap to the lowest.
  always_comb begin
    w_hi        = w_scan_mask & ~(w_scan_ptr - N'(1));
    w_pick      = (|w_hi) ? w_hi : w_scan_mask;
    w_win_found = |w_scan_mask;
    w_win_idx   = '0;
    w_win_oh    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_pick[i]) begin
        w_win_idx   = IDW'(i);
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = gnt;
    w_valid_nxt = gnt_valid;
    w_id_nxt    = gnt_id;
    w_ptr_nxt   = ptr;
`ifdef RING_ARB_HOLD_LIMIT_EN
    w_hold_nxt  = r_hold_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (w_win_found) begin
          w_gnt_nxt   = w_win_oh;
          w_valid_nxt = 1'b1;
          w_id_nxt    = w_win_idx;
          w_state_nxt = BUSY;
`ifdef RING_ARB_HOLD_LIMIT_EN
          w_hold_nxt  = '0;
`endif
        end
      end
      BUSY: begin
        if (w_release) begin
          w_ptr_nxt = w_owner_rotl;
`ifdef RING_ARB_HOLD_LIMIT_EN
          w_hold_nxt = '0;
`endif
          if (w_win_found) begin
            w_gnt_nxt   = w_win_oh;
            w_valid_nxt = 1'b1;
            w_id_nxt    = w_win_idx;
          end else begin
            w_gnt_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_id_nxt    = '0;
            w_state_nxt = IDLE;
          end
        end else begin
`ifdef RING_ARB_HOLD_LIMIT_EN
          if (r_hold_cnt != HCW'(MAX_HOLD)) w_hold_nxt = r_hold_cnt + HCW'(1);
`endif
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      gnt        <= '0;
      gnt_valid  <= 1'b0;
      gnt_id     <= '0;
      ptr        <= N'(1);
`ifdef RING_ARB_HOLD_LIMIT_EN
      r_hold_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      gnt        <= w_gnt_nxt;
      gnt_valid  <= w_valid_nxt;
      gnt_id     <= w_id_nxt;
      ptr        <= w_ptr_nxt;
`ifdef RING_ARB_HOLD_LIMIT_EN
      r_hold_cnt <= w_hold_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed testbench for ring_rr_arbiter (N=4): reset, single/simultaneous requests,
// handover without bubble, fairness order, wrap-around and the optional hold limit.
module tb_ring_rr_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic [N-1:0]   ptr;
  logic           dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  ring_rr_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .ptr       (ptr),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one rising edge, then return to the falling edge where inputs change and outputs are sampled
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_gnt, input logic e_valid,
                           input logic [1:0] e_id, input logic [3:0] e_ptr);
    check({tag, "_gnt"},   32'(gnt),       32'(e_gnt));
    check({tag, "_valid"}, 32'(gnt_valid), 32'(e_valid));
    check({tag, "_id"},    32'(gnt_id),    32'(e_id));
    check({tag, "_ptr"},   32'(ptr),       32'(e_ptr));
    check({tag, "_state"}, 32'(dbg_state), 32'(e_valid));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    logic [3:0] oh;
    logic [31:0] e;
    rst = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    tick();
    tick();
    check_all("reset", 4'b0000, 1'b0, 2'd0, 4'b0001);
    req = 4'b0000;
    rst = 1'b1;
    tick();
    check_all("idle_noreq", 4'b0000, 1'b0, 2'd0, 4'b0001);

    // single request and release
    req = 4'b0100;
    tick();
    check_all("single_gnt", 4'b0100, 1'b1, 2'd2, 4'b0001);
    req = 4'b0000;
    tick();
    check_all("single_rel", 4'b0000, 1'b0, 2'd0, 4'b1000);

    // wrap-around from ptr=1000
    req = 4'b1001;
    tick();
    check_all("wrap_gnt3", 4'b1000, 1'b1, 2'd3, 4'b1000);
    req = 4'b0001;
    tick();
    check_all("wrap_gnt0", 4'b0001, 1'b1, 2'd0, 4'b0001);
    req = 4'b0000;
    tick();
    check_all("wrap_rel", 4'b0000, 1'b0, 2'd0, 4'b0010);

    // asynchronous reset in the middle of a grant
    req = 4'b0100;
    tick();
    check_all("pre_async", 4'b0100, 1'b1, 2'd2, 4'b0010);
    #2 rst = 1'b0;
    #1 check_all("async_rst", 4'b0000, 1'b0, 2'd0, 4'b0001);
    req = 4'b0000;
    @(negedge clk);
    tick();
    rst = 1'b1;
    tick();

    // simultaneous requests resolved by ring order, no preemption, direct handover
    req = 4'b1010;
    tick();
    check_all("simul_gnt1", 4'b0010, 1'b1, 2'd1, 4'b0001);
    req = 4'b1011;
    tick();
    check_all("no_preempt", 4'b0010, 1'b1, 2'd1, 4'b0001);
    req = 4'b1000;
    tick();
    check_all("handover", 4'b1000, 1'b1, 2'd3, 4'b0100);
    req = 4'b0000;
    tick();
    check_all("simul_rel", 4'b0000, 1'b0, 2'd0, 4'b0001);

    // fairness: every owner holds two cycles, grant order 0,1,2,3,0
    exp_q = {32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      e  = exp_q.pop_front();
      oh = 4'b0001 << e[1:0];
      check("fair_c1_gnt", 32'(gnt), 32'(oh));
      check("fair_c1_id", 32'(gnt_id), e);
      check("fair_c1_valid", 32'(gnt_valid), 32'd1);
      tick();
      check("fair_c2_gnt", 32'(gnt), 32'(oh));
      check("fair_c2_valid", 32'(gnt_valid), 32'd1);
      if (g < 4) begin
        req = 4'b1111 & ~oh;
        tick();
        req = 4'b1111;
      end
    end
    req = 4'b0000;
    tick();
    check_all("fair_end", 4'b0000, 1'b0, 2'd0, 4'b0010);

    // hold limit with two constant requesters
    do_reset();
    tick();
    req = 4'b0011;
    tick();
    check_all("hold_first", 4'b0001, 1'b1, 2'd0, 4'b0001);
`ifdef RING_ARB_HOLD_LIMIT_EN
    for (int c = 2; c <= 8; c++) begin
      tick();
      check("hold_own0", 32'(gnt), 32'h1);
    end
    tick();
    check_all("hold_pre0", 4'b0010, 1'b1, 2'd1, 4'b0010);
    for (int c = 2; c <= 8; c++) begin
      tick();
      check("hold_own1", 32'(gnt), 32'h2);
    end
    tick();
    check_all("hold_pre1", 4'b0001, 1'b1, 2'd0, 4'b0100);
    // no competitor: owner keeps the grant past the limit
    req = 4'b0001;
    for (int c = 0; c < 12; c++) tick();
    check_all("hold_sat", 4'b0001, 1'b1, 2'd0, 4'b0100);
    req = 4'b0011;
    tick();
    check_all("hold_satpre", 4'b0010, 1'b1, 2'd1, 4'b0010);
`else
    for (int c = 0; c < 20; c++) begin
      tick();
      check("nohold_own0", 32'(gnt), 32'h1);
    end
    check_all("nohold_end", 4'b0001, 1'b1, 2'd0, 4'b0001);
`endif
    req = 4'b0000;
    tick();
    check("final_valid", 32'(gnt_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
